// File: rtl/ysyx_23060124_mem_arb.sv
// Round-robin arbiter that shares one memory port between the IFU and the LSU.
// One transaction is in flight at a time. A watchdog in WAIT turns a missing reply into an error response.
module ysyx_23060124_mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  input  logic                  ifu_resp_ready,
  output logic [DATA_W-1:0]     ifu_rdata,
  output logic                  ifu_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wmask,
  output logic                  lsu_resp_valid,
  input  logic                  lsu_resp_ready,
  output logic [DATA_W-1:0]     lsu_rdata,
  output logic                  lsu_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_wen,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_resp_err
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              last_grant;
  logic              owner;
  logic [15:0]       cnt;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              rst_d;
  logic              active;
  logic              resp_hs;
  logic              timeout_hit;

  // Handshake outputs stay low during reset and for one cycle after it.
  assign active = !i_rst_n && !rst_d;

  assign ifu_req_ready  = active && state == IDLE && ifu_req_valid &&
                          (!lsu_req_valid || last_grant == OWN_LSU);
  assign lsu_req_ready  = active && state == IDLE && lsu_req_valid &&
                          (!ifu_req_valid || last_grant == OWN_IFU);
  assign mem_req_valid  = active && state == ISSUE;
  assign mem_resp_ready = active && state == WAIT;
  assign ifu_resp_valid = active && state == RESP && owner == OWN_IFU;
  assign lsu_resp_valid = active && state == RESP && owner == OWN_LSU;

  assign mem_addr  = req_addr;
  assign mem_wen   = req_wen;
  assign mem_wdata = req_wdata;
  assign mem_wmask = req_wmask;
  assign ifu_rdata = resp_rdata;
  assign lsu_rdata = resp_rdata;
  assign ifu_err   = resp_err;
  assign lsu_err   = resp_err;

  assign resp_hs     = (ifu_resp_valid && ifu_resp_ready) || (lsu_resp_valid && lsu_resp_ready);
  assign timeout_hit = cnt == TO_LAST;

  always_ff @(posedge i_clk) begin
    rst_d <= i_rst_n;
    if (i_rst_n) begin
      state      <= IDLE;
      last_grant <= OWN_LSU;
      owner      <= OWN_IFU;
      cnt        <= '0;
      req_addr   <= '0;
      req_wen    <= 1'b0;
      req_wdata  <= '0;
      req_wmask  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ifu_req_ready) begin
            req_addr   <= ifu_addr;
            req_wen    <= 1'b0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            owner      <= OWN_IFU;
            last_grant <= OWN_IFU;
            state      <= ISSUE;
          end else if (lsu_req_ready) begin
            req_addr   <= lsu_addr;
            req_wen    <= lsu_wen;
            req_wdata  <= lsu_wdata;
            req_wmask  <= lsu_wmask;
            owner      <= OWN_LSU;
            last_grant <= OWN_LSU;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_valid && mem_req_ready) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 16'd1;
          // A real reply in the timeout cycle takes priority over the forced error.
          if (mem_resp_valid) begin
            resp_rdata <= req_wen ? '0 : mem_rdata;
            resp_err   <= mem_resp_err;
            state      <= RESP;
          end else if (timeout_hit) begin
            resp_rdata <= '0;
            resp_err   <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060124_mem_arb.sv
// Directed bench for the IFU/LSU memory arbiter, built with TIMEOUT = 8.
// Inputs change 1 ns after a rising edge, and outputs are checked on the falling edge.
module tb_ysyx_23060124_mem_arb;
  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, ifu_err;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready, lsu_err;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask, mem_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready, mem_resp_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_chk = 0;
  int n_pass = 0;

  ysyx_23060124_mem_arb #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready),
    .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready),
    .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready),
    .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst_n = 1'b1;
    repeat (2) tick();
    i_rst_n = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b1;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
    mem_resp_valid = 1'b1;
    repeat (2) tick();
    @(negedge i_clk);
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid} !== 6'b0)
      $display("FAIL reset_outputs got=%b want=000000",
               {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid});
    else n_pass++;
    tick();
    i_rst_n = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b00)
      $display("FAIL post_reset_ready got=%b want=00", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    tick();
    @(negedge i_clk);
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
      $display("FAIL first_tie_ifu got=%b want=10", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0; mem_resp_valid = 1'b0;
    tick();
  endtask

  task automatic test_ifu_read();
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000; mem_req_ready = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b10)
      $display("FAIL ifu_grant got=%b want=10", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    tick();
    ifu_req_valid = 1'b0; ifu_addr = 32'h0;
    @(negedge i_clk);
    n_chk++;
    if ({mem_req_valid, mem_wen, mem_addr, mem_wmask} !== {1'b1, 1'b0, 32'h8000_0000, 4'h0})
      $display("FAIL ifu_issue got=%b/%b/%h/%h want=1/0/80000000/0", mem_req_valid, mem_wen, mem_addr, mem_wmask);
    else n_pass++;
    tick();
    @(negedge i_clk);
    n_chk++;
    if (mem_resp_ready !== 1'b1) $display("FAIL wait_resp_ready got=%b want=1", mem_resp_ready);
    else n_pass++;
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413; mem_resp_err = 1'b0;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid} !== {1'b1, 32'h0000_0413, 1'b0, 1'b0})
      $display("FAIL ifu_resp got=%b/%h/%b lsu_v=%b want=1/00000413/0 lsu_v=0",
               ifu_resp_valid, ifu_rdata, ifu_err, lsu_resp_valid);
    else n_pass++;
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_resp_valid, mem_req_valid} !== 2'b00)
      $display("FAIL ifu_done got=%b want=00", {ifu_resp_valid, mem_req_valid});
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic exp_ifu;
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_0200; lsu_wen = 1'b0;
    mem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_ifu = (k != 1);
      @(negedge i_clk);
      n_chk++;
      if ({ifu_req_ready, lsu_req_ready} !== {exp_ifu, !exp_ifu})
        $display("FAIL rr_grant%0d got=%b want=%b", k, {ifu_req_ready, lsu_req_ready}, {exp_ifu, !exp_ifu});
      else n_pass++;
      tick();
      @(negedge i_clk);
      n_chk++;
      if ({ifu_req_ready, lsu_req_ready, mem_addr} !== {2'b00, exp_ifu ? 32'h8000_0100 : 32'h8000_0200})
        $display("FAIL rr_issue%0d got=%b/%h want=00/%h", k, {ifu_req_ready, lsu_req_ready}, mem_addr,
                 exp_ifu ? 32'h8000_0100 : 32'h8000_0200);
      else n_pass++;
      tick();
      mem_resp_valid = 1'b1; mem_rdata = 32'h100 + k;
      tick();
      mem_resp_valid = 1'b0;
      @(negedge i_clk);
      n_chk++;
      if ({ifu_resp_valid, lsu_resp_valid, ifu_rdata} !== {exp_ifu, !exp_ifu, 32'h100 + k})
        $display("FAIL rr_resp%0d got=%b/%h want=%b/%h", k, {ifu_resp_valid, lsu_resp_valid}, ifu_rdata,
                 {exp_ifu, !exp_ifu}, 32'h100 + k);
      else n_pass++;
      ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      tick();
      ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    tick(); tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0;
    tick();
    mem_resp_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
  endtask

  task automatic test_store();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; mem_req_ready = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_req_ready, lsu_req_ready} !== 2'b01)
      $display("FAIL store_grant got=%b want=01", {ifu_req_ready, lsu_req_ready});
    else n_pass++;
    tick();
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      @(negedge i_clk);
      n_chk++;
      if ({mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !==
          {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'b0011})
        $display("FAIL store_issue%0d got=%b/%b/%h/%h/%b want=1/1/80001000/deadbeef/0011",
                 i, mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
      else n_pass++;
      tick();
    end
    mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; mem_resp_err = 1'b0;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({lsu_resp_valid, lsu_rdata, lsu_err, ifu_resp_valid} !== {1'b1, 32'h0, 1'b0, 1'b0})
      $display("FAIL store_resp got=%b/%h/%b ifu_v=%b want=1/00000000/0 ifu_v=0",
               lsu_resp_valid, lsu_rdata, lsu_err, ifu_resp_valid);
    else n_pass++;
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040; mem_req_ready = 1'b1;
    mem_rdata = 32'hAAAA_AAAA; mem_resp_err = 1'b0;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      n_chk++;
      if ({ifu_resp_valid, mem_resp_ready} !== 2'b01)
        $display("FAIL timeout_wait%0d got=%b want=01", i, {ifu_resp_valid, mem_resp_ready});
      else n_pass++;
      tick();
    end
    @(negedge i_clk);
    n_chk++;
    if ({ifu_resp_valid, ifu_err, ifu_rdata, mem_resp_ready} !== {1'b1, 1'b1, 32'h0, 1'b0})
      $display("FAIL timeout_resp got=%b/%b/%h/%b want=1/1/00000000/0",
               ifu_resp_valid, ifu_err, ifu_rdata, mem_resp_ready);
    else n_pass++;
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0; ifu_req_valid = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_resp_valid, ifu_req_ready} !== 2'b01)
      $display("FAIL timeout_idle got=%b want=01", {ifu_resp_valid, ifu_req_ready});
    else n_pass++;
    ifu_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_timeout_coincide();
    lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000; lsu_wen = 1'b0; mem_req_ready = 1'b1;
    tick();
    lsu_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678; mem_resp_err = 1'b0;
    tick();
    mem_resp_valid = 1'b0; mem_rdata = 32'h0;
    @(negedge i_clk);
    n_chk++;
    if ({lsu_resp_valid, lsu_rdata, lsu_err} !== {1'b1, 32'h1234_5678, 1'b0})
      $display("FAIL coincide_resp got=%b/%h/%b want=1/12345678/0", lsu_resp_valid, lsu_rdata, lsu_err);
    else n_pass++;
    lsu_resp_ready = 1'b1;
    tick();
    lsu_resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080; mem_req_ready = 1'b1;
    tick();
    ifu_req_valid = 1'b0;
    tick();
    tick();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_chk++;
    if ({mem_resp_ready, ifu_resp_valid} !== 2'b00)
      $display("FAIL midrst_during got=%b want=00", {mem_resp_ready, ifu_resp_valid});
    else n_pass++;
    tick();
    i_rst_n = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0099;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      n_chk++;
      if ({ifu_resp_valid, lsu_resp_valid, mem_resp_ready} !== 3'b000)
        $display("FAIL midrst_ignore%0d got=%b want=000", i, {ifu_resp_valid, lsu_resp_valid, mem_resp_ready});
      else n_pass++;
      tick();
    end
    mem_resp_valid = 1'b0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_00C0;
    tick();
    ifu_req_valid = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({mem_req_valid, mem_addr} !== {1'b1, 32'h8000_00C0})
      $display("FAIL midrst_issue got=%b/%h want=1/800000c0", mem_req_valid, mem_addr);
    else n_pass++;
    tick();
    mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_resp_valid = 1'b0;
    @(negedge i_clk);
    n_chk++;
    if ({ifu_resp_valid, ifu_rdata, ifu_err} !== {1'b1, 32'h0000_0055, 1'b0})
      $display("FAIL midrst_resp got=%b/%h/%b want=1/00000055/0", ifu_resp_valid, ifu_rdata, ifu_err);
    else n_pass++;
    ifu_resp_ready = 1'b1;
    tick();
    ifu_resp_ready = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 32'h0; ifu_resp_ready = 1'b0;
    lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
    lsu_resp_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0; mem_resp_err = 1'b0;
    test_reset();
    test_ifu_read();
    test_round_robin();
    test_store();
    test_timeout();
    test_timeout_coincide();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ysyx_23060124_mem_arb.md
Name: ysyx_23060124_mem_arb

Overview:
- Sequences the single shared memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Round-robin arbitration with one transaction outstanding at a time.
- Each requester uses valid/ready request and response channels.
- A watchdog converts a hung memory access into an error response, so the core never deadlocks on a missing reply.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; write mask is DATA_W/8 bits.
- TIMEOUT, 255, maximum cycles spent in WAIT before a forced error response; legal range 1..65535.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous active-high reset. The port name is kept for consistency across the codebase; a value of 1 means reset.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU response available.
- ifu_resp_ready  in  1  IFU consumes response.
- ifu_rdata  out  DATA_W  fetched data.
- ifu_err  out  1  response is an error.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_wdata  in  DATA_W  store data.
- lsu_wmask  in  DATA_W/8  byte enables for the store.
- lsu_resp_valid  out  1  LSU response available.
- lsu_resp_ready  in  1  LSU consumes response.
- lsu_rdata  out  DATA_W  load data; 0 for stores.
- lsu_err  out  1  error flag.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  request address.
- mem_wen  out  1  store flag.
- mem_wdata  out  DATA_W  store data.
- mem_wmask  out  DATA_W/8  byte enables.
- mem_resp_valid  in  1  memory response.
- mem_resp_ready  out  1  arbiter accepts response.
- mem_rdata  in  DATA_W  response data.
- mem_resp_err  in  1  memory error.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Reset values: state = IDLE, last_grant = LSU, owner = IFU, timeout counter = 0, all latched request and response fields = 0. Every valid/ready output is 0 during reset and in the cycle after it. Reset mid-transaction abandons the transaction with no response; any memory reply that arrives later in IDLE is ignored (mem_resp_ready = 0).
- IDLE:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the one that is not last_grant. Because last_grant resets to LSU, the IFU wins the first tie.
  - The grant is signalled by asserting the winner's req_ready combinationally in the same cycle. The loser's req_ready stays 0.
  - On the handshake edge: latch addr, wen, wdata and wmask (IFU forces wen = 0, wmask = 0); set owner and last_grant; go to ISSUE.
- ISSUE:
  - mem_req_valid = 1 with the latched fields, held stable until mem_req_ready.
  - On handshake go to WAIT and clear the counter.
  - No timeout applies in ISSUE.
- WAIT:
  - mem_resp_ready = 1; the counter increments each cycle.
  - On mem_resp_valid: latch rdata (forced to 0 when the latched wen = 1) and err = mem_resp_err; go to RESP.
  - If the counter reaches TIMEOUT-1 with no response: err = 1, rdata = 0; go to RESP.
  - A response arriving in the same cycle as the timeout wins (real data is used).
- RESP:
  - The owner's resp_valid = 1; rdata and err are held stable. The other requester's resp_valid = 0.
  - On the owner's resp_ready handshake, go to IDLE.
  - No new request is granted in the cycle that RESP exits.
- Latency: minimum 4 cycles from request handshake to response handshake (grant, ISSUE with mem_req_ready = 1, WAIT with mem_resp_valid = 1, RESP with resp_ready = 1).
- Outside IDLE, both req_ready outputs = 0.
- Requester inputs may change freely after their handshake; only latched copies drive memory.
- mem_req_valid, once asserted, never drops before mem_req_ready.

Test Plan:
- Reset, then ifu_req_valid = 1, addr = 0x80000000; memory gives ready immediately and rdata = 0x00000413 after 2 cycles -> ifu_resp_valid with rdata 0x00000413, err = 0; lsu_resp_valid stays 0.
- IFU and LSU both valid in the first IDLE after reset -> IFU granted first, LSU granted next; with both held valid continuously, grants alternate IFU, LSU, IFU.
- LSU store: addr = 0x80001000, wdata = 0xDEADBEEF, wmask = 0b0011 -> mem_wen = 1 and the fields match; response rdata = 0; mem_req_valid is held steady for 3 cycles while mem_req_ready = 0.
- Memory never answers, TIMEOUT = 8 -> owner gets resp_valid 8 cycles after entering WAIT, with err = 1 and rdata = 0; the FSM then returns to IDLE.
- mem_resp_valid coincides with the timeout cycle, rdata = 0x12345678 -> response carries 0x12345678 and err = mem_resp_err.
- Reset asserted during WAIT, then memory replies -> no resp_valid is seen; after reset release the next IFU request completes normally.
